// File: rtl/div_unit_if.sv
// Divider handshake bundle between the EX stage and the radix-2 divider.
// The EX stage drives operands and control; the divider returns stall, done and result.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            div_valid_E;
    logic [1:0]      div_op_E;
    logic [XLEN-1:0] op_a_E;
    logic [XLEN-1:0] op_b_E;
    logic            flush_E;
    logic            mem_stall;
    logic            div_stall;
    logic [XLEN-1:0] div_result;
    logic            div_done;

    modport master (
        output div_valid_E, div_op_E, op_a_E, op_b_E, flush_E, mem_stall,
        input  div_stall, div_result, div_done
    );

    modport slave (
        input  div_valid_E, div_op_E, op_a_E, op_b_E, flush_E, mem_stall,
        output div_stall, div_result, div_done
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Operands are captured once at issue; the pipeline is stalled until the result is ready.
//   state | meaning
//   IDLE  | waiting for a divide in EX
//   CALC  | one quotient bit per cycle, XLEN cycles
//   DONE  | result valid, held while mem_stall
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic       clk,
    input logic       rst_n,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  dvsr;
    logic             neg_q;
    logic             neg_r;
    logic             is_rem;
    logic             special;
    logic             done_q;

    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] result;

    always_comb begin
        is_signed = !bus.div_op_E[0];
        sign_a    = is_signed && bus.op_a_E[XLEN-1];
        sign_b    = is_signed && bus.op_b_E[XLEN-1];
        abs_a     = sign_a ? ('0 - bus.op_a_E) : bus.op_a_E;
        abs_b     = sign_b ? ('0 - bus.op_b_E) : bus.op_b_E;
        rem_sh    = {rem, quo[XLEN-1]};
        trial     = rem_sh - {1'b0, dvsr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_rem  <= 1'b0;
            special <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_valid_E && !bus.flush_E) begin
                        is_rem <= bus.div_op_E[1];
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        if (bus.op_b_E == '0) begin
                            quo     <= ALL_ONES;
                            rem     <= bus.op_a_E;
                            special <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else if (is_signed && bus.op_a_E == MIN_NEG && bus.op_b_E == ALL_ONES) begin
                            quo     <= MIN_NEG;
                            rem     <= '0;
                            special <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            quo     <= abs_a;
                            rem     <= '0;
                            dvsr    <= abs_b;
                            special <= 1'b0;
                            cnt     <= CNT_W'(XLEN);
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A vanished divide is treated like a flush.
                    if (!bus.div_valid_E || bus.flush_E) begin
                        state <= IDLE;
                    end else begin
                        if (!trial[XLEN]) begin
                            rem <= trial[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.flush_E || !bus.mem_stall) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Special-case results are preloaded in final form and skip the sign fix.
    always_comb begin
        result = '0;
        if (is_rem) result = (neg_r && !special) ? ('0 - rem) : rem;
        else        result = (neg_q && !special) ? ('0 - quo) : quo;
    end

    assign bus.div_stall  = bus.div_valid_E && (state != DONE) && !bus.flush_E;
    assign bus.div_result = result;
    assign bus.div_done   = done_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases, randomized operations
// against an arithmetic reference, and stall/flush/reset/back-to-back timing.
module tb_div_unit;
    localparam int XLEN = 32;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } dvec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    div_unit_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa;
        int  sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00: begin
                if (b == 0) return 32'hFFFF_FFFF;
                else if (ovf) return 32'h8000_0000;
                else return 32'(sa / sb);
            end
            2'b01: begin
                if (b == 0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            2'b10: begin
                if (b == 0) return a;
                else if (ovf) return 32'h0;
                else return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // Starts at posedge+1 of the issue cycle; returns at the negedge of the first done cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [31:0] res, output int lat,
                         output int stalls, output logic stall_at_done, output bit tmo);
        bus.div_valid_E = 1'b1;
        bus.div_op_E    = op;
        bus.op_a_E      = a;
        bus.op_b_E      = b;
        stalls          = 0;
        lat             = -1;
        tmo             = 1'b1;
        res             = 'x;
        stall_at_done   = 1'bx;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.div_done === 1'b1) begin
                res           = bus.div_result;
                lat           = c;
                stall_at_done = bus.div_stall;
                tmo           = 1'b0;
                break;
            end
            if (bus.div_stall === 1'b1) stalls++;
            @(posedge clk);
            #1;
            if (scramble) begin
                bus.op_a_E = $urandom;
                bus.op_b_E = $urandom;
            end
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.div_valid_E = 1'b0;
        bus.div_op_E    = 2'b00;
        bus.op_a_E      = '0;
        bus.op_b_E      = '0;
        bus.flush_E     = 1'b0;
        bus.mem_stall   = 1'b0;
        #12;
        n_vec++;
        if (bus.div_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b want 0", bus.div_done);
        end
        n_vec++;
        if (bus.div_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h want 00000000", bus.div_result);
        end
        n_vec++;
        if (bus.div_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: got %b want 0", bus.div_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        dvec_t       tbl [9];
        logic [31:0] res;
        int          lat;
        int          stalls;
        int          exp_lat;
        logic        sad;
        bit          tmo;
        tbl[0] = '{2'b01, 32'd100,        32'd7,          32'd14};
        tbl[1] = '{2'b11, 32'd100,        32'd7,          32'd2};
        tbl[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        tbl[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        tbl[4] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
        tbl[5] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
        tbl[6] = '{2'b11, 32'd5,          32'd0,          32'd5};
        tbl[7] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        tbl[8] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
        for (int i = 0; i < 9; i++) begin
            exp_lat = ref_lat(tbl[i].op, tbl[i].a, tbl[i].b);
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, res, lat, stalls, sad, tmo);
            n_vec++;
            if (tmo || res !== tbl[i].exp) begin
                n_err++;
                $display("FAIL directed_result[%0d] op=%0d: got %h want %h (timeout=%0d)", i, tbl[i].op, res, tbl[i].exp, tmo);
            end
            n_vec++;
            if (lat !== exp_lat || stalls !== exp_lat || sad !== 1'b0) begin
                n_err++;
                $display("FAIL directed_timing[%0d]: got lat=%0d stalls=%0d stall_at_done=%b want lat=%0d stalls=%0d stall_at_done=0",
                         i, lat, stalls, sad, exp_lat, exp_lat);
            end
            @(posedge clk);
            #1;
            bus.div_valid_E = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        int          stalls;
        int          exp_lat;
        logic        sad;
        bit          tmo;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = 32'(0 - $urandom_range(1, 15));
                4: a = $urandom_range(0, 100);
                default: ;
            endcase
            exp     = ref_div(op, a, b);
            exp_lat = ref_lat(op, a, b);
            do_op(op, a, b, 1'b1, res, lat, stalls, sad, tmo);
            n_vec++;
            if (tmo || res !== exp) begin
                n_err++;
                $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp);
            end
            n_vec++;
            if (lat !== exp_lat || stalls !== exp_lat || sad !== 1'b0) begin
                n_err++;
                $display("FAIL random_timing[%0d]: got lat=%0d stalls=%0d want %0d", i, lat, stalls, exp_lat);
            end
            @(posedge clk);
            #1;
            bus.div_valid_E = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_mem_stall();
        logic [31:0] res;
        int          lat;
        int          stalls;
        logic        sad;
        bit          tmo;
        do_op(2'b01, 32'd100, 32'd7, 1'b0, res, lat, stalls, sad, tmo);
        n_vec++;
        if (tmo || res !== 32'd14) begin
            n_err++;
            $display("FAIL mem_stall_first: got %h want 0000000e", res);
        end
        bus.mem_stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            bus.op_a_E = $urandom;
            if (k == 3) bus.mem_stall = 1'b0;
            @(negedge clk);
            n_vec++;
            if (bus.div_done !== 1'b1 || bus.div_result !== 32'd14 || bus.div_stall !== 1'b0) begin
                n_err++;
                $display("FAIL mem_stall_hold[%0d]: got done=%b result=%h stall=%b want done=1 result=0000000e stall=0",
                         k, bus.div_done, bus.div_result, bus.div_stall);
            end
        end
        @(posedge clk);
        #1;
        bus.div_valid_E = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.div_done !== 1'b0) begin
            n_err++;
            $display("FAIL mem_stall_release: got done=%b want 0", bus.div_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int          lat;
        int          stalls;
        logic        sad;
        bit          tmo;
        bus.div_valid_E = 1'b1;
        bus.div_op_E    = 2'b01;
        bus.op_a_E      = 32'hFFFF_FFF0;
        bus.op_b_E      = 32'd3;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.div_done !== 1'b0 || bus.div_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_calc: got done=%b result=%h want done=0 result=00000000", bus.div_done, bus.div_result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(2'b01, 32'd9, 32'd3, 1'b0, res, lat, stalls, sad, tmo);
        n_vec++;
        if (tmo || res !== 32'd3 || lat !== XLEN + 1) begin
            n_err++;
            $display("FAIL reset_then_divu: got result=%h lat=%0d want result=00000003 lat=%0d", res, lat, XLEN + 1);
        end
        @(posedge clk);
        #1;
        bus.div_valid_E = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          stalls;
        logic        sad;
        bit          tmo;
        bus.div_valid_E = 1'b1;
        bus.div_op_E    = 2'b01;
        bus.op_a_E      = 32'd1000;
        bus.op_b_E      = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        bus.flush_E = 1'b1;
        #1;
        n_vec++;
        if (bus.div_stall !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall: got %b want 0", bus.div_stall);
        end
        @(negedge clk);
        n_vec++;
        if (bus.div_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_done: got %b want 0", bus.div_done);
        end
        @(posedge clk);
        #1;
        bus.flush_E = 1'b0;
        do_op(2'b01, 32'd20, 32'd4, 1'b0, res, lat, stalls, sad, tmo);
        n_vec++;
        if (tmo || res !== 32'd5 || lat !== XLEN + 1 || stalls !== XLEN + 1) begin
            n_err++;
            $display("FAIL flush_then_divu: got result=%h lat=%0d stalls=%0d want result=00000005 lat=%0d", res, lat, stalls, XLEN + 1);
        end
        @(posedge clk);
        #1;
        bus.div_valid_E = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res1;
        logic [31:0] res2;
        int          lat;
        int          stalls;
        int          c1;
        int          c2;
        logic        sad;
        bit          tmo1;
        bit          tmo2;
        do_op(2'b01, 32'd20, 32'd4, 1'b0, res1, lat, stalls, sad, tmo1);
        c1 = cyc;
        @(posedge clk);
        #1;
        do_op(2'b01, 32'd21, 32'd4, 1'b0, res2, lat, stalls, sad, tmo2);
        c2 = cyc;
        n_vec++;
        if (tmo1 || res1 !== 32'd5) begin
            n_err++;
            $display("FAIL b2b_first: got %h want 00000005", res1);
        end
        n_vec++;
        if (tmo2 || res2 !== 32'd5) begin
            n_err++;
            $display("FAIL b2b_second: got %h want 00000005", res2);
        end
        n_vec++;
        if (c2 - c1 !== XLEN + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", c2 - c1, XLEN + 2);
        end
        @(posedge clk);
        #1;
        bus.div_valid_E = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mem_stall();
        test_reset_mid_calc();
        test_flush();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
